// File: rtl/regfile_sequencer.sv
// regfile_sequencer: expands ALU/PUSH/POP macro-ops into timed regfile commands,
// ALU-start and memory read/write strobes, with an optional memory ack timeout.
module regfile_sequencer #(
    parameter int INDEX_WIDTH = 3,
    parameter int CMD_WIDTH   = 4,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [1:0]             i_op,
    input  logic [INDEX_WIDTH-1:0] i_rd,
    input  logic [INDEX_WIDTH-1:0] i_rs1,
    input  logic [INDEX_WIDTH-1:0] i_rs2,
    output logic [CMD_WIDTH-1:0]   o_rf_command,
    output logic [INDEX_WIDTH-1:0] o_rf_index,
    output logic                   o_alu_go,
    output logic                   o_mem_wr,
    output logic                   o_mem_rd,
    input  logic                   i_mem_ack,
    output logic                   o_done,
    output logic                   o_busy,
    output logic                   o_error
);
    localparam logic [CMD_WIDTH-1:0] COM_NOP      = CMD_WIDTH'(0);
    localparam logic [CMD_WIDTH-1:0] COM_READA    = CMD_WIDTH'(1);
    localparam logic [CMD_WIDTH-1:0] COM_READB    = CMD_WIDTH'(2);
    localparam logic [CMD_WIDTH-1:0] COM_LATCHC   = CMD_WIDTH'(3);
    localparam logic [CMD_WIDTH-1:0] COM_LATCHSEL = CMD_WIDTH'(4);
    localparam logic [CMD_WIDTH-1:0] COM_READSP   = CMD_WIDTH'(5);
    localparam logic [CMD_WIDTH-1:0] COM_SPINC    = CMD_WIDTH'(7);
    localparam logic [CMD_WIDTH-1:0] COM_SPDEC    = CMD_WIDTH'(8);
    localparam int CW = $clog2(ACK_TIMEOUT + 2);

    typedef enum logic [4:0] {
        S_IDLE, S_A1, S_A2, S_A3, S_A4, S_A5, S_A6, S_A7,
        S_P1, S_P2, S_P3, S_PW, S_PDEC,
        S_Q1, S_Q2, S_QW, S_QSEL, S_QC
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [INDEX_WIDTH-1:0] rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d, idx_q, idx_d;
    logic [CMD_WIDTH-1:0]   cmd_q, cmd_d;
    logic                   go_q, go_d, mem_wr_q, mem_wr_d, mem_rd_q, mem_rd_d;
    logic                   done_q, done_d, busy_q, busy_d, ready_q, ready_d, err_q, err_d;
    logic                   accept, timeout;

    always_comb begin
        accept  = i_valid && state_q == S_IDLE;
        rd_d    = accept ? i_rd : rd_q;
        rs1_d   = accept ? i_rs1 : rs1_q;
        rs2_d   = accept ? i_rs2 : rs2_q;
        timeout = ACK_TIMEOUT != 0 && int'(cnt_q) + 1 == ACK_TIMEOUT;
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: if (accept) begin
                state_d = i_op == 2'b00 ? S_A1 : i_op == 2'b01 ? S_P1 : i_op == 2'b10 ? S_Q1 : S_IDLE;
                err_d   = i_op == 2'b11;
            end
            S_A1: state_d = S_A2;
            S_A2: state_d = S_A3;
            S_A3: state_d = S_A4;
            S_A4: state_d = S_A5;
            S_A5: state_d = S_A6;
            S_A6: state_d = S_A7;
            S_P1: state_d = S_P2;
            S_P2: state_d = S_P3;
            S_P3: begin
                state_d = S_PW;
                cnt_d   = '0;
            end
            S_PW: begin
                state_d = i_mem_ack ? S_PDEC : timeout ? S_IDLE : S_PW;
                err_d   = !i_mem_ack && timeout;
                cnt_d   = cnt_q + 1'b1;
            end
            S_Q1: state_d = S_Q2;
            S_Q2: begin
                state_d = S_QW;
                cnt_d   = '0;
            end
            S_QW: begin
                state_d = i_mem_ack ? S_QSEL : timeout ? S_IDLE : S_QW;
                err_d   = !i_mem_ack && timeout;
                cnt_d   = cnt_q + 1'b1;
            end
            S_QSEL: state_d = S_QC;
            default: state_d = S_IDLE;
        endcase
        // outputs are decoded from the next state so they register in step with it
        cmd_d = COM_NOP;
        idx_d = '0;
        case (state_d)
            S_A1, S_P2: begin
                cmd_d = COM_LATCHSEL;
                idx_d = rs1_d;
            end
            S_A3: begin
                cmd_d = COM_LATCHSEL;
                idx_d = rs2_d;
            end
            S_A6, S_QSEL: begin
                cmd_d = COM_LATCHSEL;
                idx_d = rd_d;
            end
            S_A2, S_P3: cmd_d = COM_READA;
            S_A4:       cmd_d = COM_READB;
            S_A7, S_QC: cmd_d = COM_LATCHC;
            S_P1, S_Q2: cmd_d = COM_READSP;
            S_PDEC:     cmd_d = COM_SPDEC;
            S_Q1:       cmd_d = COM_SPINC;
            default:    cmd_d = COM_NOP;
        endcase
        go_d     = state_d == S_A5;
        mem_wr_d = state_d == S_PW;
        mem_rd_d = state_d == S_QW;
        done_d   = state_d == S_A7 || state_d == S_PDEC || state_d == S_QC;
        busy_d   = state_d != S_IDLE;
        ready_d  = state_d == S_IDLE;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            rd_q     <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            cmd_q    <= COM_NOP;
            idx_q    <= '0;
            go_q     <= 1'b0;
            mem_wr_q <= 1'b0;
            mem_rd_q <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b1;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rd_q     <= rd_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            cmd_q    <= cmd_d;
            idx_q    <= idx_d;
            go_q     <= go_d;
            mem_wr_q <= mem_wr_d;
            mem_rd_q <= mem_rd_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            ready_q  <= ready_d;
            err_q    <= err_d;
        end
    end

    assign o_ready      = ready_q;
    assign o_rf_command = cmd_q;
    assign o_rf_index   = idx_q;
    assign o_alu_go     = go_q;
    assign o_mem_wr     = mem_wr_q;
    assign o_mem_rd     = mem_rd_q;
    assign o_done       = done_q;
    assign o_busy       = busy_q;
    assign o_error      = err_q;
endmodule

// File: tb/tb_regfile_sequencer.sv
// tb_regfile_sequencer: directed macro-ops checked cycle by cycle against a step-list model.
module tb_regfile_sequencer;
    logic       i_clk = 1'b0, i_reset = 1'b1, i_valid = 1'b0, i_mem_ack = 1'b0;
    logic [1:0] i_op = 2'b00;
    logic [2:0] i_rd = 3'd0, i_rs1 = 3'd0, i_rs2 = 3'd0;
    logic       o_ready, o_alu_go, o_mem_wr, o_mem_rd, o_done, o_busy, o_error;
    logic [3:0] o_rf_command;
    logic [2:0] o_rf_index;

    regfile_sequencer dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
        .i_op(i_op), .i_rd(i_rd), .i_rs1(i_rs1), .i_rs2(i_rs2),
        .o_rf_command(o_rf_command), .o_rf_index(o_rf_index), .o_alu_go(o_alu_go),
        .o_mem_wr(o_mem_wr), .o_mem_rd(o_mem_rd), .i_mem_ack(i_mem_ack),
        .o_done(o_done), .o_busy(o_busy), .o_error(o_error)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [3:0] cmd;
        logic [2:0] idx;
        logic go, wr, rd, done, busy, ready, err;
    } obs_t;

    localparam obs_t IDLE = {4'd0, 3'd0, 4'b0000, 1'b0, 1'b1, 1'b0};
    localparam obs_t ERRC = {4'd0, 3'd0, 4'b0000, 1'b0, 1'b1, 1'b1};

    obs_t q[$];
    obs_t act;
    int   total = 0, bad = 0;
    bit   chk = 0;

    assign act = {o_rf_command, o_rf_index, o_alu_go, o_mem_wr, o_mem_rd, o_done, o_busy, o_ready, o_error};

    function automatic obs_t st(input logic [3:0] c, input logic [2:0] i, input logic go, wr, rd, dn);
        return {c, i, go, wr, rd, dn, 1'b1, 1'b0, 1'b0};
    endfunction

    // expected outputs for cycles 1.. after accept; d = ack offset into the wait, <0 = never
    function automatic void model(input logic [1:0] op, input logic [2:0] rd, rs1, rs2, input int d, input int keep);
        obs_t l[$];
        int n = d < 0 ? 15 : d + 1;
        case (op)
            2'd0: begin
                l.push_back(st(4, rs1, 0, 0, 0, 0));
                l.push_back(st(1, 0, 0, 0, 0, 0));
                l.push_back(st(4, rs2, 0, 0, 0, 0));
                l.push_back(st(2, 0, 0, 0, 0, 0));
                l.push_back(st(0, 0, 1, 0, 0, 0));
                l.push_back(st(4, rd, 0, 0, 0, 0));
                l.push_back(st(3, 0, 0, 0, 0, 1));
            end
            2'd1: begin
                l.push_back(st(5, 0, 0, 0, 0, 0));
                l.push_back(st(4, rs1, 0, 0, 0, 0));
                l.push_back(st(1, 0, 0, 0, 0, 0));
                for (int k = 0; k < n; k++) l.push_back(st(0, 0, 0, 1, 0, 0));
                l.push_back(d < 0 ? ERRC : st(8, 0, 0, 0, 0, 1));
            end
            2'd2: begin
                l.push_back(st(7, 0, 0, 0, 0, 0));
                l.push_back(st(5, 0, 0, 0, 0, 0));
                for (int k = 0; k < n; k++) l.push_back(st(0, 0, 0, 0, 1, 0));
                if (d < 0) l.push_back(ERRC);
                else begin
                    l.push_back(st(4, rd, 0, 0, 0, 0));
                    l.push_back(st(3, 0, 0, 0, 0, 1));
                end
            end
            default: l.push_back(ERRC);
        endcase
        for (int k = 0; k < keep && k < l.size(); k++) q.push_back(l[k]);
    endfunction

    always @(negedge i_clk) begin : cmp
        obs_t e;
        if (chk) begin
            e = q.size() != 0 ? q.pop_front() : IDLE;
            total++;
            if (act !== e) begin
                bad++;
                $display("FAIL cycle t=%0t got=%h want=%h", $time, act, e);
            end
            if (o_done && o_error) begin
                bad++;
                $display("FAIL done_err_overlap t=%0t got=1 want=0", $time);
            end
        end
    end

    // lit = {cmd, idx, done, err} expected in cycle lit_c; strb = cycles with a mem strobe
    task automatic run(input logic [1:0] op, input logic [2:0] rd, rs1, rs2, input int d,
                       input int rst_at, input int lit_c, input logic [8:0] lit, input int strb);
        int w, len, seen;
        @(posedge i_clk); #1;
        i_valid = 1'b1; i_op = op; i_rd = rd; i_rs1 = rs1; i_rs2 = rs2;
        @(negedge i_clk); #1;
        model(op, rd, rs1, rs2, d, rst_at < 0 ? 99 : rst_at);
        len  = q.size();
        w    = op == 2'd1 ? 4 : 3;
        seen = 0;
        for (int c = 1; c <= len + 2; c++) begin
            @(posedge i_clk); #1;
            i_valid   = c <= len - 2;
            i_op      = 2'(c);
            i_rd      = 3'(c + 1);
            i_rs1     = 3'(c + 2);
            i_rs2     = 3'(c + 3);
            i_reset   = c == rst_at;
            i_mem_ack = (d >= 0 && c == w + d) || c == len + 1;
            if (o_mem_wr || o_mem_rd) seen++;
            if (c == lit_c) begin
                total++;
                if ({o_rf_command, o_rf_index, o_done, o_error} !== lit) begin
                    bad++;
                    $display("FAIL literal op=%0d c=%0d got=%h want=%h", op, c,
                             {o_rf_command, o_rf_index, o_done, o_error}, lit);
                end
            end
        end
        i_valid = 1'b0; i_mem_ack = 1'b0; i_reset = 1'b0;
        total++;
        if (seen != strb) begin
            bad++;
            $display("FAIL strobe_count op=%0d got=%0d want=%0d", op, seen, strb);
        end
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL model_drain op=%0d got=%0d want=0", op, q.size());
        end
        q.delete();
    endtask

    initial begin
        @(posedge i_clk); #1;
        chk = 1;
        @(posedge i_clk); #1;
        i_reset = 1'b0;
        repeat (10) @(posedge i_clk);
        #1;
        total++;
        if ({o_ready, o_busy, o_rf_command} !== {1'b1, 1'b0, 4'd0}) begin
            bad++;
            $display("FAIL reset_idle got=%b want=%b", {o_ready, o_busy, o_rf_command}, 6'b100000);
        end
        run(2'd0, 3'd2, 3'd0, 3'd5, -1, -1, 7, {4'd3, 3'd0, 1'b1, 1'b0}, 0);
        run(2'd1, 3'd0, 3'd3, 3'd0, 2, -1, 7, {4'd8, 3'd0, 1'b1, 1'b0}, 3);
        run(2'd2, 3'd1, 3'd0, 3'd0, 0, -1, 5, {4'd3, 3'd0, 1'b1, 1'b0}, 1);
        run(2'd1, 3'd0, 3'd4, 3'd0, -1, -1, 19, {4'd0, 3'd0, 1'b0, 1'b1}, 15);
        run(2'd3, 3'd1, 3'd2, 3'd3, -1, -1, 1, {4'd0, 3'd0, 1'b0, 1'b1}, 0);
        run(2'd2, 3'd6, 3'd0, 3'd0, 5, -1, 10, {4'd3, 3'd0, 1'b1, 1'b0}, 6);
        run(2'd1, 3'd0, 3'd6, 3'd0, 14, -1, 19, {4'd8, 3'd0, 1'b1, 1'b0}, 15);
        run(2'd2, 3'd7, 3'd0, 3'd0, -1, -1, 18, {4'd0, 3'd0, 1'b0, 1'b1}, 15);
        run(2'd0, 3'd2, 3'd1, 3'd3, -1, 3, 4, {4'd0, 3'd0, 1'b0, 1'b0}, 0);
        run(2'd0, 3'd7, 3'd6, 3'd1, -1, -1, 3, {4'd4, 3'd1, 1'b0, 1'b0}, 0);
        chk = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
